// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encoding shared by the UART receiver and transmitter
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
  localparam int T_DEFAULT = 5208;
  localparam int DW = 8;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line plus a delayed copy for falling-edge detection
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rxd,
  output logic o_rxs,
  output logic o_fall
);
  logic [1:0] r_sync;
  logic       r_rxs_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[0], i_rxd};
      r_rxs_d <= r_sync[1];
    end
  end
  assign o_rxs  = r_sync[1];
  assign o_fall = r_rxs_d & ~r_sync[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver sampling mid-bit and pushing each byte into the RX FIFO with a one-cycle strobe
module uart_rx
  import uart_pkg::*;
#(
  parameter int T  = T_DEFAULT,
  parameter int CW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RXD,
  input  logic          full,
  output logic          wr_en,
  output logic [DW-1:0] data,
  output logic          frame_err,
  output logic          overrun,
  output logic          busy
);
  localparam logic [CW-1:0] HALF = CW'(T / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(T - 1);
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic          w_rxs;
  logic          w_fall;
  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_rxd (RXD),
    .o_rxs (w_rxs),
    .o_fall(w_fall)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      data      <= '0;
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (w_fall) r_state <= START;
        end
        // a start bit that is high again at mid-bit was a glitch
        START: if (r_cnt == HALF) begin
          r_cnt   <= '0;
          r_state <= w_rxs ? IDLE : DATA;
        end else r_cnt <= r_cnt + 1'b1;
        DATA: if (r_cnt == LAST) begin
          r_cnt       <= '0;
          data[r_idx] <= w_rxs;
          r_idx       <= r_idx + 1'b1;
          if (r_idx == 3'd7) r_state <= STOP;
        end else r_cnt <= r_cnt + 1'b1;
        // leave at mid-stop so half a bit remains to catch a back-to-back start edge
        STOP: if (r_cnt == LAST) begin
          r_cnt     <= '0;
          r_state   <= IDLE;
          wr_en     <= w_rxs & ~full;
          overrun   <= w_rxs & full;
          frame_err <= ~w_rxs;
        end else r_cnt <= r_cnt + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames checked against an outcome/timing model of the receiver
module tb_uart_rx;
  localparam int T   = 16;
  localparam int LAT = T / 2 + 9 * T + 2;
  typedef struct {
    logic [2:0] k;
    logic [7:0] d;
    int         c;
  } ev_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RXD = 1'b1;
  logic       full = 1'b0;
  logic       wr_en, frame_err, overrun, busy;
  logic [7:0] data;
  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  ev_t        obs[$];
  ev_t        expq[$];
  uart_rx #(.T(T), .CW(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RXD      (RXD),
    .full     (full),
    .wr_en    (wr_en),
    .data     (data),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (wr_en | frame_err | overrun) obs.push_back('{k: {overrun, frame_err, wr_en}, d: data, c: cyc});
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // outcome per frame: good stop -> write or overrun, bad stop -> framing error
  task automatic send(input logic [7:0] b, input logic sv);
    expq.push_back('{k: sv ? (full ? 3'b100 : 3'b001) : 3'b010, d: b, c: cyc + 1 + LAT});
    RXD = 1'b0;
    tick(T);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      tick(T);
    end
    RXD = sv;
    tick(T);
  endtask
  task automatic check_events(input string tag);
    tick(2);
    chk({tag, "_count"}, obs.size(), expq.size());
    while (obs.size() > 0 && expq.size() > 0) begin
      ev_t o = obs.pop_front();
      ev_t e = expq.pop_front();
      chk({tag, "_kind"}, {29'd0, o.k}, {29'd0, e.k});
      chk({tag, "_data"}, {24'd0, o.d}, {24'd0, e.d});
      chk({tag, "_cycle"}, o.c, e.c);
    end
    obs.delete();
    expq.delete();
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_data"}, {24'd0, data}, 32'd0);
  endtask
  initial begin
    tick(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick(T);
    send(8'hA5, 1'b1);
    check_events("a5");
    RXD = 1'b0;
    tick(4);
    RXD = 1'b1;
    tick(2 * T);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    check_events("glitch");
    send(8'h3C, 1'b1);
    check_events("3c");
    send(8'h55, 1'b0);
    tick(40);
    chk("break_data", {24'd0, data}, 32'h55);
    RXD = 1'b1;
    tick(T);
    send(8'h12, 1'b1);
    check_events("break");
    full = 1'b1;
    send(8'hFF, 1'b1);
    full = 1'b0;
    send(8'h81, 1'b1);
    check_events("overrun");
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h7E, 1'b1);
    if (obs.size() >= 3) begin
      chk("b2b_gap01", obs[1].c - obs[0].c, 10 * T);
      chk("b2b_gap12", obs[2].c - obs[1].c, 10 * T);
    end
    check_events("b2b");
    RXD = 1'b0;
    tick(T);
    for (int i = 0; i < 4; i++) begin
      RXD = i[0];
      tick(T);
    end
    tick(T / 2);
    chk("midframe_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    tick(3);
    RXD = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(T);
    check_events("midreset");
    send(8'hC3, 1'b1);
    check_events("c3");
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      logic       sv;
      b    = 8'($urandom);
      sv   = ($urandom_range(4) != 0);
      full = ($urandom_range(3) == 0);
      send(b, sv);
      full = 1'b0;
      RXD  = 1'b1;
      tick($urandom_range(T, 2));
      check_events("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: 8N1, LSB first, line idles high.
- Input RXD is asynchronous. The block recovers each byte by sampling mid-bit and pushes it into the RX FIFO with a one-cycle write strobe.
- It is the counterpart of the FIFO-fed transmitter and shares the same bit-period parameter, so both ends run at the same baud.

Parameters:
- T, 5208, clocks per bit (50 MHz / 9600 baud). Must be ≥ 8. T/2 uses integer division.
- CW, 15, width of the bit-period counter. Must satisfy 2^CW > T.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- RXD  input  1  serial line, asynchronous to clk, idle high.
- full  input  1  RX FIFO full flag.
- wr_en  output  1  one-cycle FIFO write strobe.
- data  output  8  received byte. Valid when wr_en=1 and held until the next byte completes.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good byte dropped because full=1.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, idx=0, data=8'h00, wr_en=0, frame_err=0, overrun=0, busy=0. Synchronizer flops reset to 1.
- Sync: RXD passes through 2 flops to give rxs. A third flop gives rxs_d. A start edge is fall = rxs_d & ~rxs.
- States: IDLE, START, DATA, STOP.
- IDLE: cnt=0, idx=0. On fall, go to START with cnt=0.
- START: cnt increments each cycle. At cnt==T/2-1:
  - rxs=0: go to DATA, cnt=0.
  - rxs=1: glitch. Go to IDLE; nothing is reported.
- DATA: cnt counts 0..T-1 and wraps to 0. At cnt==T-1, data[idx] <= rxs (LSB first) and idx increments. After idx 7 is sampled, go to STOP with cnt=0 and idx=0.
- Sample instants fall at mid-bit, 1.5T, 2.5T … 8.5T after the start edge. The stop bit is sampled at 9.5T.
- STOP: at cnt==T-1, sample rxs, then go to IDLE in the same cycle. Outcomes:
  - rxs=1 and full=0: wr_en=1 for exactly one cycle.
  - rxs=1 and full=1: overrun=1 for one cycle. wr_en stays 0 and the byte is dropped. data still shows the byte.
  - rxs=0: frame_err=1 for one cycle and wr_en=0, regardless of full.
- Latency: wr_en is asserted T/2 + 9T cycles after the first cycle rxs is low, plus 2 cycles of synchronizer delay from RXD.
- Back-to-back frames: the return to IDLE at mid-stop leaves 0.5T for the next start edge, so no frame is lost.
- Break / stuck low: after a frame_err the line may stay low. No new start is detected until rxs returns high and then falls again, which follows directly from the edge detector.
- data is written only during DATA sampling and is not cleared between frames.
- Pulse outputs (wr_en, frame_err, overrun) are registered, never combinational, and mutually exclusive.
- full is sampled only in the STOP decision cycle.
- Reset mid-frame returns to IDLE immediately. No pulses are issued and the partial byte is discarded.

Decomposition:
- Package uart_pkg: state encoding (IDLE=0, START=1, DATA=2, STOP=3), default T=5208, data width 8. The transmitter uses the same constants.
- Sub-module uart_rx_sync: 2-flop synchronizer plus edge register. Outputs rxs and fall; resets to line-high.

Test Plan (T=16, CW=5):
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), full=0 -> one wr_en pulse with data=8'hA5, exactly 8+144+2 cycles after RXD falls; frame_err=0, overrun=0.
- RXD low for 4 cycles, then high -> returns to IDLE with no wr_en, frame_err or overrun; the next valid 0x3C frame is received correctly.
- Frame 0x55 with stop bit driven low -> frame_err pulse, no wr_en, data=8'h55. Hold RXD low for 40 cycles, then send 0x12 -> only 0x12 is written.
- Frame 0xFF with full=1 -> overrun pulse, no wr_en. Drop full, send 0x81 -> wr_en with data=8'h81.
- Back-to-back 0x00, 0xFF, 0x7E with no idle gap -> three wr_en pulses in order, 160 cycles apart.
- Assert rst_n=0 during bit 4 of a frame -> all outputs reach reset values immediately. Release, send 0xC3 -> data=8'hC3 written once.
